fb_arbiter: RTL and testbench

Arbiter and sequencer for the single-port 24-bit × 17-bit-address framebuffer RAM, clocked by CLOCK_50. It shares the one RAM port between three users: the scanout reader (highest priority, fixed-latency reads), a pixel writer (posted writes through a small FIFO, with a starvation guard), and a built-in clear engine that fills all 200×600 words with one colour. It sits between the VGA timing block and `single_port_ram`, and owns `fb_adr`/`fb_d`/`fb_rw`.

---
 rtl/fb_arbiter.sv | 240 ++++++++++++++++++++++++
 tb/tb_fb_arbiter.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/fb_arbiter.sv
// Framebuffer RAM arbiter: scanout reads, posted pixel writes through a small FIFO,
// and a clear engine, all sharing one single-port RAM behind registered fb_* outputs.
module fb_arbiter #(
    parameter int DATA_W      = 24,
    parameter int ADR_W       = 17,
    parameter int FB_WORDS    = 120000,
    parameter int WFIFO_DEPTH = 4,
    parameter int MAX_WAIT    = 8,
    parameter int RD_LAT      = 1
) (
    input  logic                              CLOCK_50,
    input  logic                              RESET,
    input  logic                              rd_req,
    input  logic [ADR_W-1:0]                  rd_adr,
    output logic                              rd_gnt,
    output logic                              rd_valid,
    output logic [DATA_W-1:0]                 rd_data,
    input  logic                              wr_req,
    input  logic [ADR_W-1:0]                  wr_adr,
    input  logic [DATA_W-1:0]                 wr_data,
    output logic                              wr_rdy,
    input  logic                              clr_start,
    input  logic [DATA_W-1:0]                 clr_color,
    output logic                              clr_busy,
    output logic [$clog2(WFIFO_DEPTH):0]      fifo_level,
    output logic [ADR_W-1:0]                  fb_adr,
    output logic [DATA_W-1:0]                 fb_d,
    output logic                              fb_rw,
    input  logic [DATA_W-1:0]                 fb_q
);

    localparam int PTR_W = $clog2(WFIFO_DEPTH);
    localparam int LVL_W = PTR_W + 1;
    localparam int ST_W  = $clog2(MAX_WAIT + 1);

    typedef enum logic [1:0] {
        CLR_IDLE  = 2'd0,
        CLR_DRAIN = 2'd1,
        CLR_RUN   = 2'd2
    } clr_state_t;

    typedef enum logic [1:0] {
        SEL_IDLE  = 2'd0,
        SEL_READ  = 2'd1,
        SEL_WRITE = 2'd2,
        SEL_CLEAR = 2'd3
    } sel_t;

    logic [ADR_W-1:0]  fifo_adr_r  [WFIFO_DEPTH];
    logic [DATA_W-1:0] fifo_data_r [WFIFO_DEPTH];
    logic [PTR_W-1:0]  wptr_r;
    logic [PTR_W-1:0]  rptr_r;
    logic [LVL_W-1:0]  level_r;
    logic              fifo_empty_s;
    logic              fifo_full_s;
    logic              push_s;
    logic              pop_s;
    logic              wr_rdy_s;

    logic [ST_W-1:0]   starve_r;
    logic              force_s;
    sel_t              sel_s;
    logic              rd_gnt_s;

    clr_state_t        clr_state_r;
    clr_state_t        clr_next_s;
    logic [ADR_W-1:0]  clr_ptr_r;
    logic [DATA_W-1:0] clr_color_r;
    logic              clr_busy_s;
    logic              clr_last_s;

    logic [RD_LAT:0]   rd_pipe_r;
    logic [ADR_W-1:0]  fb_adr_r;
    logic [DATA_W-1:0] fb_d_r;
    logic              fb_rw_r;

    assign fifo_empty_s = (level_r == {LVL_W{1'b0}});
    assign fifo_full_s  = (level_r == LVL_W'(WFIFO_DEPTH));
    assign clr_busy_s   = (clr_state_r != CLR_IDLE);
    // A full FIFO refuses pushes even when it is popped in the same cycle.
    assign wr_rdy_s     = !fifo_full_s && !clr_busy_s && !RESET;
    assign push_s       = wr_req && wr_rdy_s;
    assign pop_s        = (sel_s == SEL_WRITE);
    assign force_s      = (starve_r == ST_W'(MAX_WAIT)) && !fifo_empty_s;
    assign clr_last_s   = (clr_ptr_r == ADR_W'(FB_WORDS - 1));

    // Pick the single RAM access for this cycle.
    always_comb begin
        sel_s    = SEL_IDLE;
        rd_gnt_s = 1'b0;
        if (force_s) begin
            sel_s = SEL_WRITE;
        end else if (rd_req) begin
            sel_s    = SEL_READ;
            rd_gnt_s = 1'b1;
        end else if (!fifo_empty_s) begin
            sel_s = SEL_WRITE;
        end else if (clr_state_r == CLR_RUN) begin
            sel_s = SEL_CLEAR;
        end else begin
            sel_s = SEL_IDLE;
        end
    end

    // Clear FSM next-state logic.
    always_comb begin
        clr_next_s = clr_state_r;
        case (clr_state_r)
            CLR_IDLE: begin
                if (clr_start) begin
                    clr_next_s = CLR_DRAIN;
                end else begin
                    clr_next_s = CLR_IDLE;
                end
            end
            CLR_DRAIN: begin
                if (fifo_empty_s) begin
                    clr_next_s = CLR_RUN;
                end else begin
                    clr_next_s = CLR_DRAIN;
                end
            end
            CLR_RUN: begin
                if ((sel_s == SEL_CLEAR) && clr_last_s) begin
                    clr_next_s = CLR_IDLE;
                end else begin
                    clr_next_s = CLR_RUN;
                end
            end
            default: clr_next_s = CLR_IDLE;
        endcase
    end

    // Clear FSM state, fill pointer and latched colour.
    always_ff @(posedge CLOCK_50) begin
        if (RESET) begin
            clr_state_r <= CLR_IDLE;
            clr_ptr_r   <= {ADR_W{1'b0}};
            clr_color_r <= {DATA_W{1'b0}};
        end else begin
            clr_state_r <= clr_next_s;
            if ((clr_state_r == CLR_IDLE) && clr_start) begin
                clr_ptr_r   <= {ADR_W{1'b0}};
                clr_color_r <= clr_color;
            end else if (sel_s == SEL_CLEAR) begin
                clr_ptr_r <= clr_ptr_r + ADR_W'(1);
            end
        end
    end

    // Write FIFO storage; entries need no reset since level gates their use.
    always_ff @(posedge CLOCK_50) begin
        if (push_s) begin
            fifo_adr_r[wptr_r]  <= wr_adr;
            fifo_data_r[wptr_r] <= wr_data;
        end
    end

    // Write FIFO pointers and occupancy.
    always_ff @(posedge CLOCK_50) begin
        if (RESET) begin
            wptr_r  <= {PTR_W{1'b0}};
            rptr_r  <= {PTR_W{1'b0}};
            level_r <= {LVL_W{1'b0}};
        end else begin
            if (push_s) begin
                wptr_r <= wptr_r + PTR_W'(1);
            end
            if (pop_s) begin
                rptr_r <= rptr_r + PTR_W'(1);
            end
            case ({push_s, pop_s})
                2'b10:   level_r <= level_r + LVL_W'(1);
                2'b01:   level_r <= level_r - LVL_W'(1);
                default: level_r <= level_r;
            endcase
        end
    end

    // Starvation counter: counts cycles a waiting FIFO head has been passed over.
    always_ff @(posedge CLOCK_50) begin
        if (RESET) begin
            starve_r <= {ST_W{1'b0}};
        end else if (fifo_empty_s || pop_s) begin
            starve_r <= {ST_W{1'b0}};
        end else if (starve_r != ST_W'(MAX_WAIT)) begin
            starve_r <= starve_r + ST_W'(1);
        end
    end

    // Registered RAM port.
    always_ff @(posedge CLOCK_50) begin
        if (RESET) begin
            fb_adr_r <= {ADR_W{1'b0}};
            fb_d_r   <= {DATA_W{1'b0}};
            fb_rw_r  <= 1'b1;
        end else begin
            case (sel_s)
                SEL_READ: begin
                    fb_adr_r <= rd_adr;
                    fb_rw_r  <= 1'b1;
                end
                SEL_WRITE: begin
                    fb_adr_r <= fifo_adr_r[rptr_r];
                    fb_d_r   <= fifo_data_r[rptr_r];
                    fb_rw_r  <= 1'b0;
                end
                SEL_CLEAR: begin
                    fb_adr_r <= clr_ptr_r;
                    fb_d_r   <= clr_color_r;
                    fb_rw_r  <= 1'b0;
                end
                default: begin
                    fb_rw_r <= 1'b1;
                end
            endcase
        end
    end

    // Read-return pipeline: one stage for the address register plus the RAM latency.
    always_ff @(posedge CLOCK_50) begin
        if (RESET) begin
            rd_pipe_r <= {(RD_LAT + 1){1'b0}};
        end else begin
            rd_pipe_r <= {rd_pipe_r[RD_LAT-1:0], rd_gnt_s};
        end
    end

    assign rd_gnt     = rd_gnt_s;
    assign rd_valid   = rd_pipe_r[RD_LAT];
    // fb_q is only meaningful while a return is due, so it is masked otherwise.
    assign rd_data    = rd_pipe_r[RD_LAT] ? fb_q : {DATA_W{1'b0}};
    assign wr_rdy     = wr_rdy_s;
    assign clr_busy   = clr_busy_s;
    assign fifo_level = level_r;
    assign fb_adr     = fb_adr_r;
    assign fb_d       = fb_d_r;
    assign fb_rw      = fb_rw_r;

endmodule

// File: tb/tb_fb_arbiter.sv
// Directed bench for fb_arbiter with a behavioural synchronous RAM and
// scoreboards for read returns and RAM writes.
module tb_fb_arbiter;

    localparam int FBW = 1000;

    logic        CLOCK_50 = 1'b0;
    logic        RESET;
    logic        rd_req;
    logic [16:0] rd_adr;
    logic        rd_gnt;
    logic        rd_valid;
    logic [23:0] rd_data;
    logic        wr_req;
    logic [16:0] wr_adr;
    logic [23:0] wr_data;
    logic        wr_rdy;
    logic        clr_start;
    logic [23:0] clr_color;
    logic        clr_busy;
    logic [2:0]  fifo_level;
    logic [16:0] fb_adr;
    logic [23:0] fb_d;
    logic        fb_rw;
    logic [23:0] fb_q;

    fb_arbiter #(.FB_WORDS(FBW)) dut (
        .CLOCK_50(CLOCK_50), .RESET(RESET),
        .rd_req(rd_req), .rd_adr(rd_adr), .rd_gnt(rd_gnt),
        .rd_valid(rd_valid), .rd_data(rd_data),
        .wr_req(wr_req), .wr_adr(wr_adr), .wr_data(wr_data), .wr_rdy(wr_rdy),
        .clr_start(clr_start), .clr_color(clr_color), .clr_busy(clr_busy),
        .fifo_level(fifo_level),
        .fb_adr(fb_adr), .fb_d(fb_d), .fb_rw(fb_rw), .fb_q(fb_q)
    );

    always #10 CLOCK_50 = ~CLOCK_50;

    function automatic logic [23:0] pat(input int i);
        return 24'h5A0000 ^ 24'(i);
    endfunction

    // Single-port RAM, one cycle read latency, preloaded on the first edge.
    logic [23:0] ram [0:FBW-1];
    logic        loaded = 1'b0;
    always @(posedge CLOCK_50) begin
        if (!loaded) begin
            for (int i = 0; i < FBW; i++) ram[i] <= pat(i);
            loaded <= 1'b1;
        end else begin
            if (!fb_rw) ram[fb_adr] <= fb_d;
            fb_q <= ram[fb_adr];
        end
    end

    typedef struct { int cyc; logic [23:0] data; } rd_exp_t;
    typedef struct { logic [16:0] adr; logic [23:0] data; } wr_exp_t;

    rd_exp_t     rq[$];
    wr_exp_t     wq[$];
    logic [23:0] exp_mem [0:FBW-1];
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          wr_cnt = 0;
    int          clr_exp = 0;
    logic [23:0] clr_col_exp = 24'h000000;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // Advance one clock: log grants/pushes before the edge, score RAM port and returns after it.
    task automatic tick();
        rd_exp_t r;
        wr_exp_t w;
        #1;
        if (rd_gnt) begin
            r.cyc  = cyc;
            r.data = exp_mem[rd_adr];
            rq.push_back(r);
        end
        if (wr_req && wr_rdy) begin
            w.adr  = wr_adr;
            w.data = wr_data;
            wq.push_back(w);
        end
        @(posedge CLOCK_50);
        cyc++;
        #2;
        if (fb_rw === 1'b0) begin
            wr_cnt++;
            if (wq.size() != 0) begin
                w = wq.pop_front();
                chk("wr_adr", 32'(fb_adr), 32'(w.adr));
                chk("wr_data", 32'(fb_d), 32'(w.data));
                exp_mem[w.adr] = w.data;
            end else begin
                chk("clr_adr", 32'(fb_adr), 32'(clr_exp));
                chk("clr_data", 32'(fb_d), 32'(clr_col_exp));
                if (clr_exp < FBW) exp_mem[clr_exp] = clr_col_exp;
                clr_exp++;
            end
        end
        if (rd_valid === 1'b1) begin
            chk("rd_pending", 32'(rq.size() != 0), 32'd1);
            if (rq.size() != 0) begin
                r = rq.pop_front();
                chk("rd_lat", 32'(cyc - r.cyc), 32'd2);
                chk("rd_data", 32'(rd_data), 32'(r.data));
            end
        end
    endtask

    initial begin
        int w0;
        bit done;
        for (int i = 0; i < FBW; i++) exp_mem[i] = pat(i);
        RESET = 1'b1; rd_req = 1'b0; rd_adr = 17'd0; wr_req = 1'b0;
        wr_adr = 17'd0; wr_data = 24'd0; clr_start = 1'b0; clr_color = 24'd0;

        // Reset state
        #1;
        chk("rst_wr_rdy", 32'(wr_rdy), 32'd0);
        for (int i = 0; i < 3; i++) tick();
        chk("rst_fb_rw", 32'(fb_rw), 32'd1);
        chk("rst_fb_adr", 32'(fb_adr), 32'd0);
        chk("rst_fb_d", 32'(fb_d), 32'd0);
        chk("rst_level", 32'(fifo_level), 32'd0);
        chk("rst_busy", 32'(clr_busy), 32'd0);
        chk("rst_rd_valid", 32'(rd_valid), 32'd0);
        chk("rst_rd_data", 32'(rd_data), 32'd0);
        RESET = 1'b0;
        #1;
        chk("post_rst_wr_rdy", 32'(wr_rdy), 32'd1);

        // Back-to-back reads, one grant per cycle
        for (int i = 0; i < 6; i++) begin
            rd_req = 1'b1; rd_adr = 17'(i);
            #1;
            chk("rd_gnt_stream", 32'(rd_gnt), 32'd1);
            tick();
        end
        rd_req = 1'b0;
        for (int i = 0; i < 3; i++) tick();
        chk("rd_stream_drained", 32'(rq.size()), 32'd0);

        // Fill the FIFO while reads hold the port, then let the writes drain
        rd_req = 1'b1; rd_adr = 17'd0;
        for (int i = 0; i < 4; i++) begin
            wr_req = 1'b1; wr_adr = 17'(10 + i); wr_data = 24'hAA0000 + 24'(i);
            #1;
            chk("fill_wr_rdy", 32'(wr_rdy), 32'd1);
            tick();
        end
        wr_req = 1'b0;
        #1;
        chk("full_wr_rdy", 32'(wr_rdy), 32'd0);
        chk("full_level", 32'(fifo_level), 32'd4);
        rd_req = 1'b0;
        w0 = wr_cnt;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("drain_wr_cnt", 32'(wr_cnt - w0), 32'(i + 1));
            chk("drain_level", 32'(fifo_level), 32'(3 - i));
        end
        for (int i = 0; i < 4; i++) begin
            rd_req = 1'b1; rd_adr = 17'(10 + i);
            tick();
        end
        rd_req = 1'b0;
        for (int i = 0; i < 3; i++) tick();

        // Starvation guard under continuous reads
        rd_req = 1'b1; rd_adr = 17'd20;
        wr_req = 1'b1; wr_adr = 17'd30; wr_data = 24'h77AA55;
        tick();
        wr_req = 1'b0;
        w0 = wr_cnt;
        for (int k = 1; k <= 12; k++) begin
            #1;
            chk("starve_gnt", 32'(rd_gnt), (k == 9) ? 32'd0 : 32'd1);
            tick();
            chk("starve_wr", 32'(wr_cnt - w0), (k >= 9) ? 32'd1 : 32'd0);
        end
        rd_req = 1'b0;
        for (int i = 0; i < 3; i++) tick();

        // Clear with two writes pending
        rd_req = 1'b1; rd_adr = 17'd1;
        for (int i = 0; i < 2; i++) begin
            wr_req = 1'b1; wr_adr = 17'(40 + i); wr_data = 24'h0BB001 + 24'(i);
            tick();
        end
        wr_req = 1'b0; rd_req = 1'b0;
        clr_start = 1'b1; clr_color = 24'h123456;
        clr_col_exp = 24'h123456; clr_exp = 0;
        tick();
        clr_start = 1'b0;
        chk("clr_busy_start", 32'(clr_busy), 32'd1);
        #1;
        chk("clr_wr_rdy", 32'(wr_rdy), 32'd0);
        done = 1'b0;
        for (int i = 0; i < FBW + 100 && !done; i++) begin
            rd_req = (i < 5); rd_adr = 17'd999;
            tick();
            if (!clr_busy) done = 1'b1;
        end
        rd_req = 1'b0;
        chk("clr_busy_end", 32'(clr_busy), 32'd0);
        chk("clr_count", 32'(clr_exp), 32'(FBW));
        chk("clr_pending_wr", 32'(wq.size()), 32'd0);
        for (int i = 0; i < 3; i++) begin
            rd_req = 1'b1; rd_adr = (i == 0) ? 17'd0 : (i == 1) ? 17'd500 : 17'd999;
            tick();
        end
        rd_req = 1'b0;
        for (int i = 0; i < 3; i++) tick();
        chk("clr_last_word", 32'(exp_mem[999]), 32'h123456);

        // Reset in the middle of a clear
        clr_start = 1'b1; clr_color = 24'h654321;
        clr_col_exp = 24'h654321; clr_exp = 0;
        tick();
        clr_start = 1'b0;
        for (int i = 0; i < 2 * FBW && clr_exp < 500; i++) tick();
        chk("mid_clr_ptr", 32'(clr_exp), 32'd500);
        RESET = 1'b1;
        #1;
        chk("mid_rst_wr_rdy", 32'(wr_rdy), 32'd0);
        w0 = wr_cnt;
        tick();
        rq.delete();
        chk("mid_rst_fb_rw", 32'(fb_rw), 32'd1);
        chk("mid_rst_busy", 32'(clr_busy), 32'd0);
        chk("mid_rst_level", 32'(fifo_level), 32'd0);
        chk("mid_rst_fb_adr", 32'(fb_adr), 32'd0);
        RESET = 1'b0;
        for (int i = 0; i < 20; i++) tick();
        chk("mid_rst_no_wr", 32'(wr_cnt - w0), 32'd0);
        for (int i = 0; i < 3; i++) begin
            rd_req = 1'b1; rd_adr = (i == 0) ? 17'd600 : (i == 1) ? 17'd500 : 17'd499;
            tick();
        end
        rd_req = 1'b0;
        for (int i = 0; i < 3; i++) tick();
        chk("adr600_kept", 32'(exp_mem[600]), 32'h123456);

        // Push attempt and pop in the same cycle at full FIFO
        rd_req = 1'b1; rd_adr = 17'd2;
        for (int i = 0; i < 4; i++) begin
            wr_req = 1'b1; wr_adr = 17'(50 + i); wr_data = 24'hC00000 + 24'(i);
            tick();
        end
        rd_req = 1'b0; wr_req = 1'b1; wr_adr = 17'd54; wr_data = 24'hC00004;
        #1;
        chk("pp_full_level", 32'(fifo_level), 32'd4);
        chk("pp_wr_rdy", 32'(wr_rdy), 32'd0);
        tick();
        wr_req = 1'b0;
        chk("pp_level_after", 32'(fifo_level), 32'd3);
        for (int i = 0; i < 6; i++) tick();
        chk("pp_drained", 32'(fifo_level), 32'd0);
        chk("end_wq_empty", 32'(wq.size()), 32'd0);
        chk("end_rq_empty", 32'(rq.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
